systolic_feeder: RTL and testbench

Front-end sequencer that drives the row-by-column systolic array. It loads one stationary weight per column through a one-hot `weight_en` sequence. It then accepts feature row-vectors over a valid/ready stream and skews them so row r reaches the array r cycles after row 0. It flushes the skew pipeline after the last vector and signals completion. It sits between the feature/weight buffers and the array's `weight_input2`/`weight_en`/`feature_input2`/`in_en`/`ctrl_in2` inputs.

---
 rtl/systolic_feeder.sv | 160 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads one stationary weight per array column, then
// streams feature row-vectors into the array with a per-row skew.
//
// Ports
//   clk_in3, rst_in3      clock, async active-high reset
//   start, busy, done     job control / status (done is a 1-cycle pulse)
//   w_data/w_valid/w_ready          weight stream (accepted in LOAD_W)
//   feat_data/feat_valid/feat_last/feat_ready  feature stream (STREAM)
//   weight_out, weight_en           per-column weights + one-hot strobe
//   feature_out, in_en              skewed features + per-row enables
//   ctrl_out                        array control, high while loading
module systolic_feeder #(
   parameter int width = 8,
   parameter int row   = 4,
   parameter int col   = 4
) (
   input  logic                   clk_in3,
   input  logic                   rst_in3,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   input  logic [width-1:0]       w_data,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [row*width-1:0]   feat_data,
   input  logic                   feat_valid,
   input  logic                   feat_last,
   output logic                   feat_ready,
   output logic [col*width-1:0]   weight_out,
   output logic [col-1:0]         weight_en,
   output logic [row*width-1:0]   feature_out,
   output logic [row-1:0]         in_en,
   output logic                   ctrl_out
);

   localparam int WCW = (col > 1) ? $clog2(col) : 1;
   localparam int FCW = (row > 1) ? $clog2(row) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_W,
      STREAM,
      FLUSH
   } state_t;

   state_t               state_q, state_d;
   logic [WCW-1:0]       wc_q, wc_d;
   logic [FCW-1:0]       fc_q, fc_d;
   logic [col*width-1:0] weight_out_q, weight_out_d;
   logic [col-1:0]       weight_en_q, weight_en_d;
   logic                 done_q, done_d;
   logic                 push_en;

   // Handshake-qualified pushes only happen in STREAM; everything
   // else shifts bubbles through the skew lanes.
   assign push_en    = (state_q == STREAM) && feat_valid;

   assign busy       = (state_q != IDLE);
   assign w_ready    = (state_q == LOAD_W);
   assign ctrl_out   = (state_q == LOAD_W);
   assign feat_ready = (state_q == STREAM);
   assign done       = done_q;
   assign weight_out = weight_out_q;
   assign weight_en  = weight_en_q;

   always_comb begin
      state_d      = state_q;
      wc_d         = wc_q;
      fc_d         = fc_q;
      weight_out_d = weight_out_q;
      weight_en_d  = '0;
      done_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_W;
               wc_d    = '0;
            end
         end
         LOAD_W: begin
            if (w_valid) begin
               for (int j = 0; j < col; j++) begin
                  if (wc_q == WCW'(j)) begin
                     weight_out_d[j*width +: width] = w_data;
                     weight_en_d[j] = 1'b1;
                  end
               end
               wc_d = wc_q + 1'b1;
               if (wc_q == WCW'(col - 1)) begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (feat_valid && feat_last) begin
               state_d = FLUSH;
               fc_d    = '0;
            end
         end
         FLUSH: begin
            fc_d = fc_q + 1'b1;
            // row bubbles drain the deepest lane; done follows.
            if (fc_q == FCW'(row - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in3 or posedge rst_in3) begin
      if (rst_in3) begin
         state_q      <= IDLE;
         wc_q         <= '0;
         fc_q         <= '0;
         weight_out_q <= '0;
         weight_en_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wc_q         <= wc_d;
         fc_q         <= fc_d;
         weight_out_q <= weight_out_d;
         weight_en_q  <= weight_en_d;
         done_q       <= done_d;
      end
   end

   // Lane r is r+1 stages deep; stage 0 sits in the low bits and the
   // oldest entry (the lane output) in the high bits.
   for (genvar r = 0; r < row; r++) begin : g_lane
      logic [(r+1)*width-1:0] dat_q, dat_d;
      logic [r:0]             en_q, en_d;

      always_comb begin
         dat_d = dat_q << width;
         dat_d[width-1:0] = push_en ?
            feat_data[r*width +: width] : '0;
         en_d    = en_q << 1;
         en_d[0] = push_en;
      end

      always_ff @(posedge clk_in3 or posedge rst_in3) begin
         if (rst_in3) begin
            dat_q <= '0;
            en_q  <= '0;
         end else begin
            dat_q <= dat_d;
            en_q  <= en_d;
         end
      end

      assign feature_out[r*width +: width] = dat_q[r*width +: width];
      assign in_en[r] = en_q[r];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (width 8, 4x4).
// Each task drives one scenario and checks its own expectations.
module tb_systolic_feeder;

   localparam int W = 8;
   localparam int R = 4;
   localparam int C = 4;

   logic           clk_in3;
   logic           rst_in3;
   logic           start;
   logic           busy;
   logic           done;
   logic [W-1:0]   w_data;
   logic           w_valid;
   logic           w_ready;
   logic [R*W-1:0] feat_data;
   logic           feat_valid;
   logic           feat_last;
   logic           feat_ready;
   logic [C*W-1:0] weight_out;
   logic [C-1:0]   weight_en;
   logic [R*W-1:0] feature_out;
   logic [R-1:0]   in_en;
   logic           ctrl_out;

   int vec;
   int miss;

   systolic_feeder #(.width(W), .row(R), .col(C)) dut (
      .clk_in3     (clk_in3),
      .rst_in3     (rst_in3),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .w_data      (w_data),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .feat_data   (feat_data),
      .feat_valid  (feat_valid),
      .feat_last   (feat_last),
      .feat_ready  (feat_ready),
      .weight_out  (weight_out),
      .weight_en   (weight_en),
      .feature_out (feature_out),
      .in_en       (in_en),
      .ctrl_out    (ctrl_out)
   );

   initial clk_in3 = 1'b0;
   always #5 clk_in3 = ~clk_in3;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_in3);
      #1;
   endtask

   task automatic load_weights(input logic [W-1:0] base);
      for (int i = 0; i < C; i++) begin
         w_valid = 1'b1;
         w_data  = base + W'(i);
         tick();
      end
      w_valid = 1'b0;
      w_data  = '0;
   endtask

   task automatic test_reset();
      rst_in3 = 1'b1;
      tick();
      for (int p = 0; p < 2; p++) begin
         vec++;
         if ({busy, done, w_ready, feat_ready, ctrl_out} !== 5'b0) begin
            $display("FAIL reset ctl p%0d: got %b want 00000", p,
                     {busy, done, w_ready, feat_ready, ctrl_out});
            miss++;
         end
         vec++;
         if ({weight_en, in_en} !== 8'h00) begin
            $display("FAIL reset en p%0d: got %h want 00", p,
                     {weight_en, in_en});
            miss++;
         end
         vec++;
         if ({weight_out, feature_out} !== 64'h0) begin
            $display("FAIL reset data p%0d: got %h want 0", p,
                     {weight_out, feature_out});
            miss++;
         end
         rst_in3 = 1'b0;
         tick();
      end
   endtask

   task automatic test_weight_load();
      logic [C-1:0] exp_we;
      start = 1'b1;
      tick();
      start = 1'b0;
      vec++;
      if ({ctrl_out, w_ready, busy, weight_en} !== 7'b1110000) begin
         $display("FAIL load entry: got %b want 1110000",
                  {ctrl_out, w_ready, busy, weight_en});
         miss++;
      end
      for (int i = 0; i < C; i++) begin
         w_valid = 1'b1;
         w_data  = W'(8'h11 * (i + 1));
         tick();
         exp_we = C'(1 << i);
         vec++;
         if (weight_en !== exp_we) begin
            $display("FAIL load we%0d: got %b want %b", i,
                     weight_en, exp_we);
            miss++;
         end
         vec++;
         if (weight_out[i*W +: W] !== W'(8'h11 * (i + 1))) begin
            $display("FAIL load wo%0d: got %h want %h", i,
                     weight_out[i*W +: W], 8'h11 * (i + 1));
            miss++;
         end
      end
      w_valid = 1'b0;
      vec++;
      if (weight_out !== 32'h44332211) begin
         $display("FAIL load all: got %h want 44332211", weight_out);
         miss++;
      end
      vec++;
      if ({ctrl_out, w_ready, feat_ready} !== 3'b001) begin
         $display("FAIL load exit: got %b want 001",
                  {ctrl_out, w_ready, feat_ready});
         miss++;
      end
   endtask

   // Vector k is accepted on tick j=k; lane r shows it on tick j=k+r.
   task automatic test_skew_done();
      logic [W-1:0] exp_d;
      logic         exp_e;
      int           k;
      for (int j = 0; j < 7; j++) begin
         if (j < 3) begin
            feat_valid = 1'b1;
            feat_last  = (j == 2);
            for (int r = 0; r < R; r++)
               feat_data[r*W +: W] = W'(16 * j + r);
         end else begin
            feat_valid = 1'b0;
            feat_last  = 1'b0;
            feat_data  = '0;
         end
         tick();
         for (int r = 0; r < R; r++) begin
            k     = j - r;
            exp_e = (k >= 0) && (k < 3);
            exp_d = exp_e ? W'(16 * k + r) : '0;
            vec++;
            if (in_en[r] !== exp_e ||
                feature_out[r*W +: W] !== exp_d) begin
               $display("FAIL skew j%0d lane%0d: got %b/%h want %b/%h",
                        j, r, in_en[r], feature_out[r*W +: W],
                        exp_e, exp_d);
               miss++;
            end
         end
         vec++;
         if (done !== (j == 6) || busy !== (j < 6)) begin
            $display("FAIL skew done j%0d: got %b%b want %b%b", j,
                     done, busy, j == 6, j < 6);
            miss++;
         end
      end
      // start in the done cycle is accepted.
      start = 1'b1;
      tick();
      start = 1'b0;
      vec++;
      if ({ctrl_out, busy, done} !== 3'b110) begin
         $display("FAIL start on done: got %b want 110",
                  {ctrl_out, busy, done});
         miss++;
      end
   endtask

   // Accepts on ticks 0, 3, 4 (last); start held high is ignored.
   task automatic test_stalls();
      int acc[5];
      logic [W-1:0] exp_d;
      logic         exp_e;
      int           e;
      int           k;
      acc = '{0, -1, -1, 1, 2};
      load_weights(8'h50);
      start = 1'b1;
      for (int j = 0; j < 9; j++) begin
         if (j < 5 && acc[j] >= 0) begin
            feat_valid = 1'b1;
            feat_last  = (acc[j] == 2);
            for (int r = 0; r < R; r++)
               feat_data[r*W +: W] = W'(16 * acc[j] + r);
         end else begin
            feat_valid = 1'b0;
            feat_last  = 1'b0;
            feat_data  = '1;
         end
         tick();
         for (int r = 0; r < R; r++) begin
            e     = j - r;
            k     = (e >= 0 && e < 5) ? acc[e] : -1;
            exp_e = (k >= 0);
            exp_d = exp_e ? W'(16 * k + r) : '0;
            vec++;
            if (in_en[r] !== exp_e ||
                feature_out[r*W +: W] !== exp_d) begin
               $display("FAIL stall j%0d lane%0d: got %b/%h want %b/%h",
                        j, r, in_en[r], feature_out[r*W +: W],
                        exp_e, exp_d);
               miss++;
            end
         end
         vec++;
         if (done !== (j == 8) || ctrl_out !== 1'b0) begin
            $display("FAIL stall done j%0d: got %b%b want %b0", j,
                     done, ctrl_out, j == 8);
            miss++;
         end
      end
      start = 1'b0;
      feat_data = '0;
      tick();
      vec++;
      if (weight_out !== 32'h53525150 || busy !== 1'b0) begin
         $display("FAIL retain: got %h/%b want 53525150/0",
                  weight_out, busy);
         miss++;
      end
   endtask

   task automatic test_handshake_stalls();
      logic         pat_v[7];
      logic [C-1:0] pat_we[7];
      logic [W-1:0] d;
      d      = 8'hA0;
      pat_v  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      pat_we = '{4'b0001, 4'b0010, 4'b0000, 4'b0000,
                 4'b0000, 4'b0100, 4'b1000};
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < 7; j++) begin
         w_valid = pat_v[j];
         w_data  = pat_v[j] ? d : 8'hEE;
         if (pat_v[j]) d = d + 1'b1;
         tick();
         vec++;
         if (weight_en !== pat_we[j] ||
             feat_ready !== (j == 6) || w_ready !== (j != 6)) begin
            $display("FAIL hs j%0d: got %b/%b%b want %b/%b%b", j,
                     weight_en, feat_ready, w_ready,
                     pat_we[j], j == 6, j != 6);
            miss++;
         end
      end
      w_valid = 1'b0;
      vec++;
      if (weight_out !== 32'hA3A2A1A0) begin
         $display("FAIL hs weights: got %h want a3a2a1a0", weight_out);
         miss++;
      end
      for (int j = 0; j < 5; j++) begin
         feat_valid = (j == 0);
         feat_last  = (j == 0);
         tick();
         vec++;
         if (done !== (j == 4)) begin
            $display("FAIL hs done j%0d: got %b want %b", j,
                     done, j == 4);
            miss++;
         end
      end
      feat_valid = 1'b0;
      feat_last  = 1'b0;
   endtask

   task automatic test_reset_mid_stream();
      logic [W-1:0] exp_d;
      start = 1'b1;
      tick();
      start = 1'b0;
      load_weights(8'h60);
      feat_valid = 1'b1;
      feat_data  = 32'h04030201;
      tick();
      tick();
      #2 rst_in3 = 1'b1;
      #1;
      vec++;
      if ({busy, done, w_ready, feat_ready, ctrl_out,
           weight_en, in_en} !== 13'h0) begin
         $display("FAIL mid rst ctl: got %b want 0",
                  {busy, done, w_ready, feat_ready, ctrl_out,
                   weight_en, in_en});
         miss++;
      end
      vec++;
      if ({weight_out, feature_out} !== 64'h0) begin
         $display("FAIL mid rst data: got %h want 0",
                  {weight_out, feature_out});
         miss++;
      end
      feat_valid = 1'b0;
      feat_data  = '0;
      tick();
      rst_in3 = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         vec++;
         if ({done, busy, in_en} !== 6'b0) begin
            $display("FAIL post rst j%0d: got %b want 0", j,
                     {done, busy, in_en});
            miss++;
         end
      end
      // Clean minimum job: done 1+col+1+row cycles after start.
      start = 1'b1;
      tick();
      start = 1'b0;
      load_weights(8'h70);
      feat_valid = 1'b1;
      feat_last  = 1'b1;
      feat_data  = 32'hC3C2C1C0;
      for (int j = 0; j < 5; j++) begin
         tick();
         feat_valid = 1'b0;
         feat_last  = 1'b0;
         feat_data  = '0;
         for (int r = 0; r < R; r++) begin
            exp_d = (j == r) ? W'(8'hC0 + r) : '0;
            vec++;
            if (in_en[r] !== (j == r) ||
                feature_out[r*W +: W] !== exp_d) begin
               $display("FAIL clean j%0d lane%0d: got %b/%h want %b/%h",
                        j, r, in_en[r], feature_out[r*W +: W],
                        j == r, exp_d);
               miss++;
            end
         end
         vec++;
         if (done !== (j == 4)) begin
            $display("FAIL clean done j%0d: got %b want %b", j,
                     done, j == 4);
            miss++;
         end
      end
      vec++;
      if (weight_out !== 32'h73727170) begin
         $display("FAIL clean weights: got %h want 73727170",
                  weight_out);
         miss++;
      end
   endtask

   initial begin
      vec        = 0;
      miss       = 0;
      rst_in3    = 1'b1;
      start      = 1'b0;
      w_data     = '0;
      w_valid    = 1'b0;
      feat_data  = '0;
      feat_valid = 1'b0;
      feat_last  = 1'b0;
      test_reset();
      test_weight_load();
      test_skew_done();
      test_stalls();
      test_handshake_stalls();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
